// File: rtl/vm_pkg.sv
// vm_pkg: shared definitions for the multi-slot vending-machine controller.
//   - vm_state_e   : controller state encoding (doubles as the status code)
//   - STATUS_*     : 4-bit status codes presented on the status output
//   - COIN_ONE/TEN : accepted coin values
//   - price_of()   : extracts one slot price from a packed price vector
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } vm_state_e;

    localparam logic [3:0] STATUS_IDLE    = 4'd0;
    localparam logic [3:0] STATUS_COLLECT = 4'd1;
    localparam logic [3:0] STATUS_VEND    = 4'd2;
    localparam logic [3:0] STATUS_CHANGE  = 4'd3;

    localparam int unsigned COIN_ONE = 1;
    localparam int unsigned COIN_TEN = 10;

    // Widest packed price vector price_of() accepts (8 slots x 32 bits).
    localparam int unsigned PRICE_VEC_MAX = 256;

    function automatic logic [3:0] status_of(input vm_state_e s);
        case (s)
            ST_IDLE:    status_of = STATUS_IDLE;
            ST_COLLECT: status_of = STATUS_COLLECT;
            ST_VEND:    status_of = STATUS_VEND;
            default:    status_of = STATUS_CHANGE;
        endcase
    endfunction

    // Slot idx occupies bits [idx*width +: width] of prices.
    function automatic logic [31:0] price_of(input logic [PRICE_VEC_MAX-1:0] prices,
                                             input int unsigned idx,
                                             input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        price_of = 32'(prices >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/vm_multi_ctrl_if.sv
// vm_multi_ctrl_if: front-panel / actuator bundle of the vending controller.
//   master : front panel + dispenser side (drives coins, cancel, buy, restock, vend_ack)
//   slave  : controller side (drives occupy, credit, vend_*, ret_*, coin_reject,
//            err_funds, sold_out, status)
interface vm_multi_ctrl_if #(
    parameter int unsigned NUM_GOODS = 4,
    parameter int unsigned CREDIT_W  = 8
);
    localparam int unsigned IDX_W = (NUM_GOODS > 1) ? $clog2(NUM_GOODS) : 1;

    logic                 one_yuan;
    logic                 ten_yuan;
    logic                 cancel;
    logic [NUM_GOODS-1:0] buy;
    logic                 restock;
    logic                 vend_ack;

    logic                 occupy;
    logic [CREDIT_W-1:0]  credit;
    logic                 vend_valid;
    logic [IDX_W-1:0]     vend_idx;
    logic                 ret_ten;
    logic                 ret_one;
    logic                 coin_reject;
    logic                 err_funds;
    logic [NUM_GOODS-1:0] sold_out;
    logic [3:0]           status;

    modport master (
        output one_yuan, ten_yuan, cancel, buy, restock, vend_ack,
        input  occupy, credit, vend_valid, vend_idx, ret_ten, ret_one,
               coin_reject, err_funds, sold_out, status
    );

    modport slave (
        input  one_yuan, ten_yuan, cancel, buy, restock, vend_ack,
        output occupy, credit, vend_valid, vend_idx, ret_ten, ret_one,
               coin_reject, err_funds, sold_out, status
    );

endinterface

// File: rtl/vm_change_disp.sv
// vm_change_disp: paced change dispenser.
//   clk, rst (async, active-low)
//   start      : load credit_in and begin paying out (ignored while busy or if 0)
//   credit_in  : amount to return
//   ret_ten    : registered pulse, one ten-yuan coin returned
//   ret_one    : registered pulse, one one-yuan coin returned
//   done       : high in the cycle whose closing edge issues the final pulse
//   credit_out : remaining credit (already reduced by the pulse being shown)
// First pulse follows the loading edge by one cycle, then one every RET_GAP cycles.
module vm_change_disp #(
    parameter int unsigned CREDIT_W = 8,
    parameter int unsigned RET_GAP  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CREDIT_W-1:0] credit_in,
    output logic                ret_ten,
    output logic                ret_one,
    output logic                done,
    output logic [CREDIT_W-1:0] credit_out
);
    import vm_pkg::*;

    localparam int unsigned         GAP_W = (RET_GAP > 1) ? $clog2(RET_GAP) : 1;
    localparam logic [CREDIT_W-1:0] TEN   = CREDIT_W'(COIN_TEN);
    localparam logic [CREDIT_W-1:0] ONE   = CREDIT_W'(COIN_ONE);

    logic                active_q, active_d;
    logic [CREDIT_W-1:0] cred_q, cred_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                ret_ten_q, ret_ten_d;
    logic                ret_one_q, ret_one_d;

    always_comb begin
        active_d  = active_q;
        cred_d    = cred_q;
        gap_d     = gap_q;
        ret_ten_d = 1'b0;
        ret_one_d = 1'b0;
        done      = 1'b0;
        if (!active_q) begin
            if (start && (credit_in != '0)) begin
                active_d = 1'b1;
                cred_d   = credit_in;
                gap_d    = '0;
            end
        end else if (gap_q == '0) begin
            if (cred_q >= TEN) begin
                ret_ten_d = 1'b1;
                cred_d    = cred_q - TEN;
            end else begin
                ret_one_d = 1'b1;
                cred_d    = cred_q - ONE;
            end
            gap_d = GAP_W'(RET_GAP - 1);
            if (cred_d == '0) begin
                active_d = 1'b0;
                done     = 1'b1;
            end
        end else begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_q  <= 1'b0;
            cred_q    <= '0;
            gap_q     <= '0;
            ret_ten_q <= 1'b0;
            ret_one_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            cred_q    <= cred_d;
            gap_q     <= gap_d;
            ret_ten_q <= ret_ten_d;
            ret_one_q <= ret_one_d;
        end
    end

    assign ret_ten    = ret_ten_q;
    assign ret_one    = ret_one_q;
    assign credit_out = cred_q;

endmodule

// File: rtl/vm_multi_ctrl.sv
// vm_multi_ctrl: NUM_GOODS-slot vending-machine controller.
//   clk, rst (async, active-low)
//   bus.slave inputs : one_yuan, ten_yuan, cancel, buy[], restock, vend_ack
//   bus.slave outputs: occupy, credit, vend_valid, vend_idx, ret_ten, ret_one,
//                      coin_reject, err_funds, sold_out[], status
// Holds the session FSM, per-slot stock and idle timeout; change payout is
// delegated to vm_change_disp, which owns the credit while in CHANGE.
module vm_multi_ctrl #(
    parameter int unsigned                   NUM_GOODS   = 4,
    parameter int unsigned                   CREDIT_W    = 8,
    parameter logic [NUM_GOODS*CREDIT_W-1:0] PRICES      = {8'd25, 8'd15, 8'd10, 8'd5},
    parameter int unsigned                   CREDIT_MAX  = 99,
    parameter int unsigned                   STOCK_W     = 4,
    parameter int unsigned                   STOCK_INIT  = 8,
    parameter int unsigned                   TIMEOUT_CYC = 1000,
    parameter int unsigned                   RET_GAP     = 4
) (
    input  logic           clk,
    input  logic           rst,
    vm_multi_ctrl_if.slave bus
);
    import vm_pkg::*;

    localparam int unsigned      IDX_W    = (NUM_GOODS > 1) ? $clog2(NUM_GOODS) : 1;
    localparam int unsigned      TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    vm_state_e            state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [STOCK_W-1:0]   stock_q [NUM_GOODS];
    logic [STOCK_W-1:0]   stock_d [NUM_GOODS];
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 vend_valid_q, vend_valid_d;
    logic [IDX_W-1:0]     vend_idx_q, vend_idx_d;
    logic                 coin_rej_q, coin_rej_d;
    logic                 err_funds_q, err_funds_d;
    logic [NUM_GOODS-1:0] sold_out_q, sold_out_d;

    logic                 chg_start, chg_done, chg_ten, chg_one;
    logic [CREDIT_W-1:0]  chg_credit;

    logic                 buy_any, sel_empty;
    logic [IDX_W-1:0]     buy_sel;
    logic [CREDIT_W-1:0]  sel_price;
    logic                 coin_any, coin_both, coin_ovf;
    logic [CREDIT_W:0]    coin_sum;

    // Lowest-index buy request wins.
    always_comb begin
        buy_any   = 1'b0;
        buy_sel   = '0;
        sel_price = '0;
        sel_empty = 1'b1;
        for (int unsigned i = 0; i < NUM_GOODS; i++) begin
            if (bus.buy[i] && !buy_any) begin
                buy_any   = 1'b1;
                buy_sel   = IDX_W'(i);
                sel_price = CREDIT_W'(price_of(PRICE_VEC_MAX'(PRICES), i, CREDIT_W));
                sel_empty = (stock_q[i] == '0);
            end
        end
    end

    always_comb begin
        coin_any  = bus.one_yuan | bus.ten_yuan;
        coin_both = bus.one_yuan & bus.ten_yuan;
        coin_sum  = {1'b0, credit_q} + (bus.ten_yuan ? (CREDIT_W+1)'(COIN_TEN)
                                                     : (CREDIT_W+1)'(COIN_ONE));
        coin_ovf  = coin_sum > (CREDIT_W+1)'(CREDIT_MAX);
    end

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        stock_d      = stock_q;
        tmo_d        = '0;
        vend_valid_d = vend_valid_q;
        vend_idx_d   = vend_idx_q;
        coin_rej_d   = 1'b0;
        err_funds_d  = 1'b0;
        chg_start    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.restock) begin
                    for (int unsigned i = 0; i < NUM_GOODS; i++) begin
                        stock_d[i] = STOCK_W'(STOCK_INIT);
                    end
                end
                if (coin_any && !coin_both && !coin_ovf) begin
                    state_d  = ST_COLLECT;
                    credit_d = coin_sum[CREDIT_W-1:0];
                end else begin
                    coin_rej_d = coin_any;
                end
            end

            ST_COLLECT: begin
                if (bus.cancel) begin
                    coin_rej_d = coin_any;
                    if (credit_q != '0) begin
                        state_d   = ST_CHANGE;
                        chg_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (buy_any) begin
                    coin_rej_d = coin_any;
                    if (!sel_empty) begin
                        if (credit_q < sel_price) begin
                            err_funds_d = 1'b1;
                        end else begin
                            credit_d     = credit_q - sel_price;
                            vend_idx_d   = buy_sel;
                            vend_valid_d = 1'b1;
                            state_d      = ST_VEND;
                            for (int unsigned i = 0; i < NUM_GOODS; i++) begin
                                if (IDX_W'(i) == buy_sel) begin
                                    stock_d[i] = stock_q[i] - 1'b1;
                                end
                            end
                        end
                    end
                end else if (coin_any && !coin_both && !coin_ovf) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                end else begin
                    // No accepted activity: a rejected coin does not hold off the timeout.
                    coin_rej_d = coin_any;
                    if (tmo_q == TMO_LAST) begin
                        if (credit_q != '0) begin
                            state_d   = ST_CHANGE;
                            chg_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end

            ST_VEND: begin
                coin_rej_d = coin_any;
                if (bus.vend_ack) begin
                    vend_valid_d = 1'b0;
                    if (credit_q != '0) begin
                        state_d   = ST_CHANGE;
                        chg_start = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                coin_rej_d = coin_any;
                if (chg_done) begin
                    state_d  = ST_IDLE;
                    credit_d = '0;
                end
            end
        endcase

        for (int unsigned i = 0; i < NUM_GOODS; i++) begin
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            credit_q     <= '0;
            for (int unsigned i = 0; i < NUM_GOODS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
            tmo_q        <= '0;
            vend_valid_q <= 1'b0;
            vend_idx_q   <= '0;
            coin_rej_q   <= 1'b0;
            err_funds_q  <= 1'b0;
            sold_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            stock_q      <= stock_d;
            tmo_q        <= tmo_d;
            vend_valid_q <= vend_valid_d;
            vend_idx_q   <= vend_idx_d;
            coin_rej_q   <= coin_rej_d;
            err_funds_q  <= err_funds_d;
            sold_out_q   <= sold_out_d;
        end
    end

    vm_change_disp #(
        .CREDIT_W (CREDIT_W),
        .RET_GAP  (RET_GAP)
    ) u_change (
        .clk        (clk),
        .rst        (rst),
        .start      (chg_start),
        .credit_in  (credit_q),
        .ret_ten    (chg_ten),
        .ret_one    (chg_one),
        .done       (chg_done),
        .credit_out (chg_credit)
    );

    assign bus.occupy      = (state_q != ST_IDLE);
    assign bus.credit      = (state_q == ST_CHANGE) ? chg_credit : credit_q;
    assign bus.vend_valid  = vend_valid_q;
    assign bus.vend_idx    = vend_idx_q;
    assign bus.ret_ten     = chg_ten;
    assign bus.ret_one     = chg_one;
    assign bus.coin_reject = coin_rej_q;
    assign bus.err_funds   = err_funds_q;
    assign bus.sold_out    = sold_out_q;
    assign bus.status      = status_of(state_q);

endmodule

// File: tb/tb_vm_multi_ctrl.sv
// tb_vm_multi_ctrl: directed, self-checking bench for vm_multi_ctrl.
// Expected change pulses and vend indices are queued when stimulus is driven
// and popped by a monitor when the DUT produces them.
module tb_vm_multi_ctrl;

    localparam int unsigned NG  = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned RG  = 4;
    localparam int unsigned TMO = 1000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vm_multi_ctrl_if #(.NUM_GOODS(NG), .CREDIT_W(CW)) bus ();

    vm_multi_ctrl #(
        .NUM_GOODS   (NG),
        .CREDIT_W    (CW),
        .PRICES      ({8'd25, 8'd15, 8'd10, 8'd5}),
        .CREDIT_MAX  (99),
        .STOCK_W     (4),
        .STOCK_INIT  (8),
        .TIMEOUT_CYC (TMO),
        .RET_GAP     (RG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned exp_ret[$];
    int unsigned exp_vend[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: change pulses and vend requests.
    int unsigned last_cyc = 0;
    bit          have_last = 1'b0;
    logic        prev_vv = 1'b0;

    always @(negedge clk) begin
        if (bus.ret_ten === 1'b1 || bus.ret_one === 1'b1) begin
            check("ret_exclusive", {31'b0, bus.ret_ten & bus.ret_one}, 32'd0);
            if (exp_ret.size() == 0) begin
                check("ret_unexpected", bus.ret_ten ? 32'd10 : 32'd1, 32'd0);
            end else begin
                int unsigned e;
                e = exp_ret.pop_front();
                check("ret_kind", bus.ret_ten ? 32'd10 : 32'd1, e);
                if (have_last) check("ret_gap", cyc - last_cyc, RG);
                last_cyc  = cyc;
                have_last = (exp_ret.size() != 0);
            end
        end
        if (bus.vend_valid === 1'b1 && prev_vv !== 1'b1) begin
            if (exp_vend.size() == 0) begin
                check("vend_unexpected", {30'b0, bus.vend_idx} + 32'd100, 32'd0);
            end else begin
                int unsigned v;
                v = exp_vend.pop_front();
                check("vend_idx", {30'b0, bus.vend_idx}, v);
            end
        end
        prev_vv = bus.vend_valid;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic coin(input bit ten);
        if (ten) bus.ten_yuan = 1'b1;
        else     bus.one_yuan = 1'b1;
        tick();
        bus.ten_yuan = 1'b0;
        bus.one_yuan = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_ret.size() != 0; k++) tick();
        tick();
        check("drain_left", exp_ret.size(), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        bus.one_yuan = 1'b0;
        bus.ten_yuan = 1'b0;
        bus.cancel   = 1'b0;
        bus.buy      = '0;
        bus.restock  = 1'b0;
        bus.vend_ack = 1'b0;
        tick(3);

        // Reset state
        check("rst_status", bus.status, 32'd0);
        check("rst_credit", bus.credit, 32'd0);
        check("rst_occupy", bus.occupy, 32'd0);
        check("rst_vend_valid", bus.vend_valid, 32'd0);
        check("rst_sold_out", bus.sold_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // 10 + 10, buy slot 2 (15), change 5 x one-yuan
        coin(1'b1);
        check("t1_status_collect", bus.status, 32'd1);
        check("t1_credit10", bus.credit, 32'd10);
        check("t1_occupy", bus.occupy, 32'd1);
        coin(1'b1);
        check("t1_credit20", bus.credit, 32'd20);
        exp_vend.push_back(2);
        bus.buy = 4'b0100;
        tick();
        bus.buy = '0;
        check("t1_status_vend", bus.status, 32'd2);
        check("t1_credit5", bus.credit, 32'd5);
        check("t1_vend_valid", bus.vend_valid, 32'd1);
        check("t1_vend_idx", bus.vend_idx, 32'd2);
        check("t1_stock2", dut.stock_q[2], 32'd7);
        tick(2);
        check("t1_vend_hold", bus.vend_valid, 32'd1);
        repeat (5) exp_ret.push_back(1);
        bus.vend_ack = 1'b1;
        tick();
        bus.vend_ack = 1'b0;
        check("t1_status_change", bus.status, 32'd3);
        check("t1_vend_drop", bus.vend_valid, 32'd0);
        tick();
        check("t1_first_ret_one", bus.ret_one, 32'd1);
        check("t1_credit4", bus.credit, 32'd4);
        drain();
        check("t1_idle", bus.status, 32'd0);
        check("t1_credit0", bus.credit, 32'd0);
        check("t1_occupy0", bus.occupy, 32'd0);

        // Credit 5, buy slot 3 (25): insufficient funds
        repeat (5) coin(1'b0);
        check("t2_credit5", bus.credit, 32'd5);
        bus.buy = 4'b1000;
        tick();
        bus.buy = '0;
        check("t2_err_funds", bus.err_funds, 32'd1);
        check("t2_credit_kept", bus.credit, 32'd5);
        check("t2_status", bus.status, 32'd1);
        check("t2_stock3", dut.stock_q[3], 32'd8);
        check("t2_no_vend", bus.vend_valid, 32'd0);
        tick();
        check("t2_err_pulse_end", bus.err_funds, 32'd0);
        bus.one_yuan = 1'b1;
        bus.ten_yuan = 1'b1;
        tick();
        bus.one_yuan = 1'b0;
        bus.ten_yuan = 1'b0;
        check("t2_both_reject", bus.coin_reject, 32'd1);
        check("t2_both_credit", bus.credit, 32'd5);

        // Fill to 95, overflow reject, cancel -> 9 ten + 5 one
        repeat (9) coin(1'b1);
        check("t3_credit95", bus.credit, 32'd95);
        coin(1'b1);
        check("t3_ovf_reject", bus.coin_reject, 32'd1);
        check("t3_ovf_credit", bus.credit, 32'd95);
        repeat (9) exp_ret.push_back(10);
        repeat (5) exp_ret.push_back(1);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        check("t3_status_change", bus.status, 32'd3);
        check("t3_credit_entry", bus.credit, 32'd95);
        bus.one_yuan = 1'b1;
        tick();
        bus.one_yuan = 1'b0;
        check("t3_first_ret_ten", bus.ret_ten, 32'd1);
        check("t3_credit85", bus.credit, 32'd85);
        check("t3_change_coin_reject", bus.coin_reject, 32'd1);
        drain();
        check("t3_idle", bus.status, 32'd0);
        check("t3_credit0", bus.credit, 32'd0);

        // Empty slot 0 with 8 purchases, then restock
        for (int n = 0; n < 8; n++) begin
            repeat (5) coin(1'b0);
            exp_vend.push_back(0);
            bus.buy = 4'b0001;
            tick();
            bus.buy = '0;
            bus.vend_ack = 1'b1;
            tick();
            bus.vend_ack = 1'b0;
        end
        check("t4_idle", bus.status, 32'd0);
        check("t4_sold_out", bus.sold_out, 32'd1);
        check("t4_stock0", dut.stock_q[0], 32'd0);
        repeat (5) coin(1'b0);
        bus.buy = 4'b0001;
        tick();
        bus.buy = '0;
        check("t4_soldout_status", bus.status, 32'd1);
        check("t4_soldout_novend", bus.vend_valid, 32'd0);
        check("t4_soldout_credit", bus.credit, 32'd5);
        repeat (5) exp_ret.push_back(1);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        drain();
        bus.restock = 1'b1;
        tick();
        bus.restock = 1'b0;
        check("t4_restock_sold_out", bus.sold_out, 32'd0);
        check("t4_restock_stock0", dut.stock_q[0], 32'd8);

        // Timeout after TIMEOUT_CYC idle cycles
        coin(1'b0);
        tick(TMO - 1);
        check("t5_before_timeout", bus.status, 32'd1);
        exp_ret.push_back(1);
        tick();
        check("t5_timeout_change", bus.status, 32'd3);
        drain();
        check("t5_idle", bus.status, 32'd0);

        // cancel beats buy in the same cycle
        coin(1'b1);
        check("t5_credit10", bus.credit, 32'd10);
        exp_ret.push_back(10);
        bus.cancel = 1'b1;
        bus.buy    = 4'b0010;
        tick();
        bus.cancel = 1'b0;
        bus.buy    = '0;
        check("t5_cancel_wins", bus.status, 32'd3);
        check("t5_cancel_novend", bus.vend_valid, 32'd0);
        check("t5_cancel_credit", bus.credit, 32'd10);
        drain();

        // Asynchronous reset during VEND with credit 12
        coin(1'b1);
        coin(1'b1);
        coin(1'b0);
        coin(1'b0);
        bus.buy = 4'b0010;
        tick();
        bus.buy = '0;
        check("t6_status_vend", bus.status, 32'd2);
        check("t6_credit12", bus.credit, 32'd12);
        check("t6_vend_idx", bus.vend_idx, 32'd1);
        check("t6_stock1_pre", dut.stock_q[1], 32'd7);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_status", bus.status, 32'd0);
        check("t6_rst_credit", bus.credit, 32'd0);
        check("t6_rst_vend_valid", bus.vend_valid, 32'd0);
        check("t6_rst_vend_idx", bus.vend_idx, 32'd0);
        check("t6_rst_occupy", bus.occupy, 32'd0);
        check("t6_rst_sold_out", bus.sold_out, 32'd0);
        check("t6_rst_stock1", dut.stock_q[1], 32'd8);
        @(negedge clk);
        rst = 1'b1;
        tick(20);
        check("t6_post_status", bus.status, 32'd0);
        check("t6_post_credit", bus.credit, 32'd0);
        check("vend_queue_left", exp_vend.size(), 32'd0);
        check("ret_queue_left", exp_ret.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vm_multi_ctrl.md
Name: vm_multi_ctrl

Overview:
Parametrised vending-machine controller, the successor to the two-good VM core.
- Serves NUM_GOODS products, each with its own price and per-slot stock counter.
- Accepts one-yuan and ten-yuan coins, with saturation and coin rejection.
- Times out idle sessions and dispenses change as a paced sequence of ten-yuan and one-yuan pulses.
- Sits between the debounced front-panel inputs and the display and dispense actuators.

Parameters:
- NUM_GOODS, 4: number of product slots (1..8).
- CREDIT_W, 8: width of credit and price values.
- PRICES, {8'd25,8'd15,8'd10,8'd5}: packed NUM_GOODS*CREDIT_W vector; slot i is at bits [i*CREDIT_W +: CREDIT_W].
- CREDIT_MAX, 99: highest credit allowed.
- STOCK_W, 4: stock counter width.
- STOCK_INIT, 8: stock value loaded at reset and on restock.
- TIMEOUT_CYC, 1000: idle cycles in COLLECT before an automatic cancel.
- RET_GAP, 4: cycles between change pulses (must be at least 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- one_yuan  in  1  single-cycle pulse: one-yuan coin inserted
- ten_yuan  in  1  single-cycle pulse: ten-yuan coin inserted
- cancel  in  1  single-cycle pulse: abort session
- buy  in  NUM_GOODS  single-cycle pulses: purchase request per slot
- restock  in  1  pulse: reload all stock to STOCK_INIT (honoured only in IDLE)
- vend_ack  in  1  dispenser confirms goods released
- occupy  out  1  session active (any state except IDLE)
- credit  out  CREDIT_W  current credit, for the display
- vend_valid  out  1  dispense request, held until vend_ack
- vend_idx  out  $clog2(NUM_GOODS) (minimum 1)  slot being dispensed
- ret_ten  out  1  pulse: return one ten-yuan coin
- ret_one  out  1  pulse: return one one-yuan coin
- coin_reject  out  1  pulse: the inserted coin was not accepted
- err_funds  out  1  pulse: buy refused, credit below price
- sold_out  out  NUM_GOODS  registered, stock[i]==0
- status  out  4  state encoding, for debug and display

Behaviour:
Reset:
- State IDLE, credit 0, all stock = STOCK_INIT.
- All pulse outputs 0, vend_valid 0, vend_idx 0, sold_out 0, timeout counter 0.

State machine and transitions (all outputs registered):
- IDLE:
  - A coin goes to COLLECT with credit = coin value.
  - buy and cancel are ignored.
  - restock reloads all stock counters.
- COLLECT:
  - A coin adds 1 or 10 to credit. If the new total would exceed CREDIT_MAX, credit is unchanged and coin_reject pulses.
  - Every accepted coin or buy attempt resets the timeout counter.
  - buy: the lowest set index i wins. If stock[i]==0, no action. If credit<price[i], err_funds pulses. Otherwise credit-=price[i], stock[i]-=1, vend_idx=i, vend_valid=1 on the next cycle, and the state goes to VEND.
  - cancel, or the timeout counter reaching TIMEOUT_CYC-1, goes to CHANGE.
- VEND:
  - Hold vend_valid until the cycle vend_ack is sampled high.
  - Then go to CHANGE if credit>0, else IDLE.
  - cancel is ignored. Coins pulse coin_reject.
- CHANGE:
  - Emit one pulse every RET_GAP cycles: ret_ten with credit-=10 while credit>=10, else ret_one with credit-=1.
  - The first pulse is issued on the cycle after entry.
  - Go to IDLE on the cycle credit reaches 0. Entering with credit 0 goes straight to IDLE.
  - Coins pulse coin_reject.

Simultaneous events in COLLECT:
- cancel beats buy, which beats a coin.
- A coin arriving with a buy or cancel in the same cycle is rejected (coin_reject).
- one_yuan and ten_yuan together: both are rejected.

Other rules:
- Never more than one ret_* pulse in a cycle.
- Credit never underflows or exceeds CREDIT_MAX.
- Stock is never decremented below 0.
- Reset mid-session: the state returns to IDLE immediately and credit is lost (accepted behaviour, documented for the field).
- status encoding: IDLE=0, COLLECT=1, VEND=2, CHANGE=3.

Decomposition:
- Package vm_pkg holds:
  - the state enum and status codes
  - the coin value constants COIN_ONE=1 and COIN_TEN=10
  - a function price_of(PRICES, i)
- Sub-module vm_change_disp:
  - Inputs: clk, rst, start, credit_in.
  - Outputs: ret_ten, ret_one, done, credit_out.
  - Owns the RET_GAP pacing counter and the ten/one decomposition.
- The top level holds the FSM, stock array and timeout counter.

Test Plan:
- Reset, then ten_yuan, ten_yuan, buy[2] (price 15), ack → vend_idx=2, credit 5, then exactly 5 ret_one pulses RET_GAP apart, then IDLE; stock[2]=7.
- Credit 5, buy[3] (price 25) → err_funds pulses, credit stays 5, stock unchanged, state COLLECT.
- Coins to credit 95, then ten_yuan → coin_reject, credit 95; cancel → 9 ret_ten then 5 ret_one, credit 0, IDLE.
- buy[0] 8 times with credit ≥ 40 → sold_out[0]=1; a further buy[0] gives no vend, credit unchanged; restock in IDLE clears sold_out.
- one_yuan, then TIMEOUT_CYC idle cycles → CHANGE, single ret_one; cancel and buy[1] in the same cycle → cancel wins, no vend.
- Drive rst low during VEND with credit 12 → all outputs at reset values asynchronously, stock=STOCK_INIT, no ret pulses after release.
